// File: rtl/adder_pipe_nbit_pkg.sv
// Shared ALU definitions for the pipelined addition path: slice width,
// pipeline depth derivation and the ADD/SUB opcode encoding used by the
// ALU decoder.
package adder_pipe_nbit_pkg;

    // Width of the operand slice handled by one pipeline stage.
    localparam int SLICE_W = 4;

    // Add/subtract select, shared with the ALU decoder.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_e;

    // Number of pipeline stages needed for an operand of the given width.
    function automatic int stage_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit ripple adder with carry in and carry out; one copy
// is used per pipeline stage of adder_pipe_nbit.
module adder_4bit
    import adder_pipe_nbit_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    // One extra bit on the left captures the carry out of the slice.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined N-bit adder/subtractor. Each stage adds one 4-bit slice and
// registers its carry for the next stage, so the critical path is a single
// 4-bit add whatever WIDTH is. Operand slices not yet consumed are carried
// forward in shrinking delay registers; result slices already produced are
// carried forward in growing registers, so the full SUM leaves the last
// stage aligned. The whole pipe freezes when the output is stalled.
module adder_pipe_nbit
    import adder_pipe_nbit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int STAGES = stage_count(WIDTH);

    // Reject widths that do not split into whole slices.
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("adder_pipe_nbit: WIDTH must be a non-zero multiple of 4");
    end

    logic             advance;
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is A + ~B + 1; CIN only matters for addition.
    assign sub_mode = (SUB == OP_SUB);
    assign b_eff    = B ^ {WIDTH{sub_mode}};
    assign cin_eff  = sub_mode | CIN;

    // The pipe moves as a whole: either the output slot is empty or it is
    // being taken this cycle. Bubbles are shifted, never collapsed.
    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = advance;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // Operand bits still to be added, this stage's slice at the bottom.
        localparam int SRC_W = WIDTH - s * SLICE_W;
        // Result bits produced by earlier stages.
        localparam int LO_W  = s * SLICE_W;

        logic [SRC_W-1:0]        a_src;
        logic [SRC_W-1:0]        b_src;
        logic                    c_src;
        logic                    v_src;
        logic [SLICE_W-1:0]      slice_sum;
        logic                    slice_cout;
        logic [LO_W+SLICE_W-1:0] sum_nxt;
        logic [LO_W+SLICE_W-1:0] sum_q;
        logic                    c_q;
        logic                    v_q;

        if (s == 0) begin : g_src
            assign a_src   = A;
            assign b_src   = b_eff;
            assign c_src   = cin_eff;
            assign v_src   = IN_VALID;
            assign sum_nxt = slice_sum;
        end else begin : g_src
            assign a_src   = g_stage[s-1].g_dly.a_q;
            assign b_src   = g_stage[s-1].g_dly.b_q;
            assign c_src   = g_stage[s-1].c_q;
            assign v_src   = g_stage[s-1].v_q;
            assign sum_nxt = {slice_sum, g_stage[s-1].sum_q};
        end

        adder_4bit u_add (
            .a    (a_src[SLICE_W-1:0]),
            .b    (b_src[SLICE_W-1:0]),
            .cin  (c_src),
            .sum  (slice_sum),
            .cout (slice_cout)
        );

        // Stage register: valid, slice carry and the accumulated low result.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                v_q   <= v_src;
                c_q   <= slice_cout;
                sum_q <= sum_nxt;
            end
        end

        // Upper operand slices wait here until their own stage is reached.
        if (SRC_W > SLICE_W) begin : g_dly
            logic [SRC_W-SLICE_W-1:0] a_q;
            logic [SRC_W-SLICE_W-1:0] b_q;

            // Delay the not-yet-added operand slices by one stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src[SRC_W-1:SLICE_W];
                    b_q <= b_src[SRC_W-1:SLICE_W];
                end
            end
        end

        // The top slice carries the sign bits, so overflow is resolved here.
        if (s == STAGES - 1) begin : g_last
            logic ovf_nxt;
            logic ovf_q;

            assign ovf_nxt = (a_src[SLICE_W-1] == b_src[SLICE_W-1]) &&
                             (slice_sum[SLICE_W-1] != a_src[SLICE_W-1]);

            // Register signed overflow alongside the final slice.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_nxt;
                end
            end
        end
    end

    assign OUT_VALID = g_stage[STAGES-1].v_q;
    assign SUM       = g_stage[STAGES-1].sum_q;
    assign COUT      = g_stage[STAGES-1].c_q;
    assign OVF       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: a 16-bit instance driven by directed and random
// beats and checked against an arithmetic reference model with an expected
// queue, plus 4-bit and 32-bit instances for latency.
module tb_adder_pipe_nbit;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, sub, cout, ovf;

    logic        v4, ir4, ov4, rdy4, cin4, sub4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;
    logic        v32, ir32, ov32, rdy32, cin32, sub32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    logic chk_lat  = 1'b0;
    exp_t exp_q[$];

    adder_pipe_nbit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .CIN(cin), .SUB(sub), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .SUM(sum), .COUT(cout), .OVF(ovf)
    );

    adder_pipe_nbit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .IN_VALID(v4), .IN_READY(ir4),
        .A(a4), .B(b4), .CIN(cin4), .SUB(sub4), .OUT_VALID(ov4),
        .OUT_READY(rdy4), .SUM(sum4), .COUT(cout4), .OVF(ovf4)
    );

    adder_pipe_nbit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .IN_VALID(v32), .IN_READY(ir32),
        .A(a32), .B(b32), .CIN(cin32), .SUB(sub32), .OUT_VALID(ov32),
        .OUT_READY(rdy32), .SUM(sum32), .COUT(cout32), .OVF(ovf32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Reference: true integer arithmetic, then wrap and range-check.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic c, input logic s);
        exp_t e;
        int   ua, ub, u, sa, sb, r;
        ua = int'(av);
        ub = int'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (s) begin
            u      = ua - ub;
            r      = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            u      = ua + ub + int'(c);
            r      = sa + sb + int'(c);
            e.cout = (u > 65535);
        end
        e.sum = 16'(u);
        e.ovf = (r > 32767) || (r < -32768);
        e.cyc = 0;
        return e;
    endfunction

    // One clock cycle on the 16-bit instance: drive, score output, tick.
    task automatic cycle(input logic v, input logic [15:0] av, input logic [15:0] bv,
                         input logic c, input logic s, input logic ordy, output logic acc);
        exp_t e;
        in_valid  = v;
        a         = av;
        b         = bv;
        cin       = c;
        sub       = s;
        out_ready = ordy;
        #2;
        acc = in_valid && in_ready;
        if (out_valid && !out_ready)
            check("stall_in_ready", 64'(in_ready), 64'(0));
        if (out_valid && out_ready) begin
            check("out_has_expect", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
                check("ovf", 64'(ovf), 64'(e.ovf));
                if (chk_lat)
                    check("latency", 64'(cyc - e.cyc), 64'(4));
                n_out++;
            end
        end
        if (acc) begin
            e     = model(av, bv, c, s);
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic        acc;
        logic [15:0] sa_q[6];
        logic [15:0] sb_q[6];
        logic        sc_q[6];
        logic        ss_q[6];
        logic [15:0] held;
        int          sent, stalls, got0, n;
        logic        released;

        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 0;
        v4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0; rdy4 = 1;
        v32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; rdy32 = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_in_ready4", 64'(ir4), 64'(1));
        check("rst_in_ready32", 64'(ir32), 64'(1));

        // Carry across the stage-1 boundary, 4-cycle latency
        chk_lat = 1'b1;
        cycle(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        check("accept_00ff", 64'(acc), 64'(1));
        drain();

        // Back-to-back ADD beats: wrap with carry, then signed overflow
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        drain();

        // SUB beats with CIN=1 (must be ignored)
        cycle(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, acc);
        cycle(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, acc);
        drain();

        // Six streamed beats with a 3-cycle output stall
        chk_lat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sa_q[i] = 16'($urandom);
            sb_q[i] = 16'($urandom);
            sc_q[i] = 1'($urandom);
            ss_q[i] = 1'($urandom);
        end
        sent = 0; stalls = 0; got0 = n_out; held = '0; released = 1'b0;
        for (int t = 0; t < 60 && (n_out - got0) < 6; t++) begin
            logic ordy;
            int   idx;
            ordy = 1'b1;
            if (out_valid && stalls < 3) begin
                ordy = 1'b0;
                if (stalls == 0) held = sum;
                else check("stall_sum_hold", 64'(sum), 64'(held));
                stalls++;
            end else if (stalls == 3 && !released) begin
                check("stall_release_sum", 64'(sum), 64'(held));
                released = 1'b1;
            end
            idx = (sent < 6) ? sent : 0;
            cycle(sent < 6, sa_q[idx], sb_q[idx], sc_q[idx], ss_q[idx], ordy, acc);
            if (acc) sent++;
        end
        check("stream_count", 64'(n_out - got0), 64'(6));
        check("stream_stalls", 64'(stalls), 64'(3));
        check("stream_empty", 64'(exp_q.size()), 64'(0));

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++)
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, acc);
        drain();

        // Reset with three beats in flight
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, acc);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        exp_q.delete();
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_sum", 64'(sum), 64'(0));
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, acc);
        check("post_rst_accept", 64'(acc), 64'(1));
        drain();

        // WIDTH=4: one-cycle latency, -7 + -8 overflows
        a4 = 4'h9; b4 = 4'h8; v4 = 1'b1;
        @(posedge clk);
        #1;
        v4 = 1'b0;
        n = 1;
        while (!ov4 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w4_latency", 64'(n), 64'(1));
        check("w4_sum", 64'(sum4), 64'(4'h1));
        check("w4_cout", 64'(cout4), 64'(1));
        check("w4_ovf", 64'(ovf4), 64'(1));

        // WIDTH=32: eight-cycle latency
        a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; v32 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        n = 1;
        while (!ov32 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w32_latency", 64'(n), 64'(8));
        check("w32_sum", 64'(sum32), 64'(32'h8000_0000));
        check("w32_cout", 64'(cout32), 64'(0));
        check("w32_ovf", 64'(ovf32), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
